// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the wait-state multicycle MIPS controller:
// FSM states, opcode/funct values, datapath mux and ALU select codes.
package mc_ctrl_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned STATE_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ERR = 3'd7
  } state_t;

  localparam logic [OP_W-1:0] OP_R   = 6'h00;
  localparam logic [OP_W-1:0] OP_ORI = 6'h0D;
  localparam logic [OP_W-1:0] OP_LW  = 6'h23;
  localparam logic [OP_W-1:0] OP_SW  = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ = 6'h04;
  localparam logic [OP_W-1:0] OP_J   = 6'h02;

  localparam logic [OP_W-1:0] FN_ADDU = 6'h21;
  localparam logic [OP_W-1:0] FN_SUBU = 6'h23;
  localparam logic [OP_W-1:0] FN_AND  = 6'h24;
  localparam logic [OP_W-1:0] FN_OR   = 6'h25;
  localparam logic [OP_W-1:0] FN_SLT  = 6'h2A;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'd4;

  localparam logic [SEL_W-1:0] PC_SEQ = 2'b00;
  localparam logic [SEL_W-1:0] PC_BR  = 2'b01;
  localparam logic [SEL_W-1:0] PC_JMP = 2'b10;

  localparam logic [SEL_W-1:0] RD_RT = 2'b00;
  localparam logic [SEL_W-1:0] RD_RD = 2'b01;

  // True for every opcode/funct pair the controller can execute.
  function automatic logic is_legal(input logic [OP_W-1:0] op, input logic [OP_W-1:0] fn);
    case (op)
      OP_R:                               return fn inside {FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT};
      OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic [ALU_OP_W-1:0] funct_alu(input logic [OP_W-1:0] fn);
    case (fn)
      FN_SUBU: return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_ws_if.sv
// Controller-to-datapath/memory bundle: IR and flag inputs, memory handshake,
// datapath control strobes and debug state.
interface mc_ctrl_ws_if;
  import mc_ctrl_pkg::*;

  logic [INSTR_W-1:0]  instr;
  logic                zero;
  logic                mem_rdy;
  logic                mem_req;
  logic                mem_we;
  logic                i_or_d;
  logic                ir_wr;
  logic                pc_wr;
  logic [SEL_W-1:0]    pc_src;
  logic                reg_we;
  logic [SEL_W-1:0]    reg_dst;
  logic                mem_to_reg;
  logic                alu_src;
  logic                ext_op;
  logic [ALU_OP_W-1:0] alu_op;
  logic                retire;
  logic                err;
  logic [STATE_W-1:0]  state;

  modport master (
    input  instr, zero, mem_rdy,
    output mem_req, mem_we, i_or_d, ir_wr, pc_wr, pc_src, reg_we, reg_dst,
           mem_to_reg, alu_src, ext_op, alu_op, retire, err, state
  );

  modport slave (
    output instr, zero, mem_rdy,
    input  mem_req, mem_we, i_or_d, ir_wr, pc_wr, pc_src, reg_we, reg_dst,
           mem_to_reg, alu_src, ext_op, alu_op, retire, err, state
  );
endinterface

// File: rtl/mc_wait_timer.sv
// Memory wait-state counter with watchdog compare; flags a hung access once
// MAX_WAIT+1 consecutive unready cycles have been seen.
module mc_wait_timer #(
  parameter int unsigned MAX_WAIT   = 15,
  parameter int unsigned WAIT_W     = 4,
  parameter bit          EN_TIMEOUT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic mem_rdy,
  output logic timeout_c
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;

  // Outside an access state the count sits at zero, so entry always starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (active && !mem_rdy) begin
      if (wait_cnt != MAX_CNT) wait_cnt <= wait_cnt + WAIT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  assign timeout_c = EN_TIMEOUT && active && !mem_rdy && (wait_cnt == MAX_CNT);

endmodule

// File: rtl/mc_ctrl_ws.sv
// Multicycle MIPS control FSM with memory req/rdy wait states, watchdog and
// sticky error state.
module mc_ctrl_ws
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT   = 15,
  parameter int unsigned WAIT_W     = 4,
  parameter bit          EN_TIMEOUT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  mc_ctrl_ws_if.master bus
);

  state_t              state_q, state_d;
  logic [OP_W-1:0]     opcode, funct;
  logic                active_c, timeout_c;
  logic                mem_req_c, mem_we_c, ir_wr_c, pc_wr_c, reg_we_c, retire_c;
  logic                i_or_d_c, mem_to_reg_c, alu_src_c, ext_op_c;
  logic [SEL_W-1:0]    pc_src_c, reg_dst_c;
  logic [ALU_OP_W-1:0] alu_op_c;
  logic                unused_instr;

  assign opcode       = bus.instr[31:26];
  assign funct        = bus.instr[5:0];
  assign unused_instr = ^bus.instr[25:6];
  assign active_c     = (state_q == S_IF) || (state_q == S_MEM);

  mc_wait_timer #(
    .MAX_WAIT  (MAX_WAIT),
    .WAIT_W    (WAIT_W),
    .EN_TIMEOUT(EN_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .active   (active_c),
    .mem_rdy  (bus.mem_rdy),
    .timeout_c(timeout_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  // Next state and control decode; mem_rdy wins over a coincident timeout.
  always_comb begin
    state_d      = state_q;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    ir_wr_c      = 1'b0;
    pc_wr_c      = 1'b0;
    reg_we_c     = 1'b0;
    retire_c     = 1'b0;
    i_or_d_c     = 1'b0;
    pc_src_c     = PC_SEQ;
    reg_dst_c    = RD_RT;
    mem_to_reg_c = 1'b0;
    alu_src_c    = 1'b0;
    ext_op_c     = 1'b0;
    alu_op_c     = ALU_ADD;
    case (state_q)
      S_IF: begin
        mem_req_c = 1'b1;
        if (bus.mem_rdy) begin
          ir_wr_c = 1'b1;
          pc_wr_c = 1'b1;
          state_d = S_ID;
        end else if (timeout_c) begin
          state_d = S_ERR;
        end
      end
      S_ID: begin
        if (!is_legal(opcode, funct)) begin
          state_d = S_ERR;
        end else if (opcode == OP_J) begin
          pc_wr_c  = 1'b1;
          pc_src_c = PC_JMP;
          retire_c = 1'b1;
          state_d  = S_IF;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        case (opcode)
          OP_R: begin
            alu_op_c = funct_alu(funct);
            state_d  = S_WB;
          end
          OP_ORI: begin
            alu_src_c = 1'b1;
            alu_op_c  = ALU_OR;
            state_d   = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_c = 1'b1;
            ext_op_c  = 1'b1;
            state_d   = S_MEM;
          end
          OP_BEQ: begin
            alu_op_c = ALU_SUB;
            pc_wr_c  = bus.zero;
            pc_src_c = PC_BR;
            retire_c = 1'b1;
            state_d  = S_IF;
          end
          default: state_d = S_ERR;
        endcase
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        i_or_d_c  = 1'b1;
        mem_we_c  = (opcode == OP_SW);
        if (bus.mem_rdy) begin
          retire_c = (opcode == OP_SW);
          state_d  = (opcode == OP_SW) ? S_IF : S_WB;
        end else if (timeout_c) begin
          state_d = S_ERR;
        end
      end
      S_WB: begin
        reg_we_c     = 1'b1;
        retire_c     = 1'b1;
        reg_dst_c    = (opcode == OP_R) ? RD_RD : RD_RT;
        mem_to_reg_c = (opcode == OP_LW);
        state_d      = S_IF;
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  // Strobes are squashed while reset is held so an in-flight access is abandoned.
  assign bus.mem_req    = mem_req_c & ~rst;
  assign bus.mem_we     = mem_we_c  & ~rst;
  assign bus.ir_wr      = ir_wr_c   & ~rst;
  assign bus.pc_wr      = pc_wr_c   & ~rst;
  assign bus.reg_we     = reg_we_c  & ~rst;
  assign bus.retire     = retire_c  & ~rst;
  assign bus.i_or_d     = i_or_d_c;
  assign bus.pc_src     = pc_src_c;
  assign bus.reg_dst    = reg_dst_c;
  assign bus.mem_to_reg = mem_to_reg_c;
  assign bus.alu_src    = alu_src_c;
  assign bus.ext_op     = ext_op_c;
  assign bus.alu_op     = alu_op_c;
  assign bus.err        = (state_q == S_ERR);
  assign bus.state      = state_q;

endmodule
